// File: rtl/audio_ice40_fc_mac_array.sv
// audio_ice40_fc_mac_array: multi-lane FC MAC array with bias init, capture/saturate and cascade drain
module audio_ice40_fc_mac_array #(
    parameter int DW         = 16,
    parameter int WW         = 16,
    parameter int AW         = 40,
    parameter int LANES      = 4,
    parameter int BIAS_DEPTH = 64,
    parameter int BIAS_SHIFT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_bias_we,
    input  logic [$clog2(BIAS_DEPTH)-1:0] i_bias_waddr,
    input  logic [LANES*16-1:0]           i_bias_wdata,
    input  logic [$clog2(BIAS_DEPTH)-1:0] i_bias_addr,
    input  logic                          i_init_bias,
    input  logic                          i_run,
    input  logic [DW-1:0]                 i_din,
    input  logic                          i_din_val,
    input  logic [LANES*WW-1:0]           i_weight,
    input  logic                          i_relu,
    input  logic [5:0]                    i_out_shift,
    input  logic                          i_shift,
    input  logic [15:0]                   i_cascade_in,
    output logic [15:0]                   o_cascade_out,
    output logic [LANES*16-1:0]           o_result,
    output logic                          o_done,
    output logic [LANES-1:0]              o_sat
);
    localparam int PW = DW + WW;
    localparam logic signed [AW-1:0] MAXV = AW'(32767);
    localparam logic signed [AW-1:0] MINV = -AW'(32768);

    logic [DW-1:0]              din_q;
    logic [LANES*WW-1:0]        w_q;
    logic                       v_q, v1_q;
    logic signed [PW-1:0]       prod_q [LANES];
    logic signed [AW-1:0]       acc_q [LANES];
    logic signed [AW-1:0]       r [LANES];
    logic [LANES*16-1:0]        mem [BIAS_DEPTH];
    logic [LANES*16-1:0]        bias_q;
    logic                       init_q;
    logic [2:0]                 run_q;
    logic                       done_q;
    logic                       cap;
    logic [LANES-1:0][15:0]     res_q, res_d, chain_q;
    logic [LANES-1:0]           sat_q, sat_d;

    // Capture fires once the last in-window sample has been flushed through the accumulator
    assign cap = run_q[2] & ~run_q[1];

    // Bias memory: synchronous write only, contents survive reset undefined
    always_ff @(posedge clk) begin
        if (i_bias_we) mem[i_bias_waddr] <= i_bias_wdata;
    end

    // S0: register the broadcast sample and weights inside the run window, zero outside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q <= '0;
            w_q   <= '0;
            v_q   <= 1'b0;
        end else begin
            din_q <= (i_run && i_din_val) ? i_din : '0;
            w_q   <= i_run ? i_weight : '0;
            v_q   <= i_run & i_din_val;
        end
    end

    // S1 multiply, bias read, and S2 accumulate where a pending bias load overrides the product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            bias_q <= '0;
            init_q <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                prod_q[n] <= '0;
                acc_q[n]  <= '0;
            end
        end else begin
            v1_q   <= v_q;
            bias_q <= mem[i_bias_addr];
            init_q <= i_init_bias;
            for (int n = 0; n < LANES; n++) begin
                prod_q[n] <= $signed(din_q) * $signed(w_q[WW*n +: WW]);
                acc_q[n]  <= init_q ? ({{(AW-16){bias_q[16*n+15]}}, bias_q[16*n +: 16]} << BIAS_SHIFT)
                           : v1_q ? acc_q[n] + {{(AW-PW){prod_q[n][PW-1]}}, prod_q[n]}
                           : acc_q[n];
            end
        end
    end

    // Per-lane output scaling, optional ReLU and saturation to 16 bits
    always_comb begin
        res_d = '0;
        sat_d = '0;
        for (int n = 0; n < LANES; n++) begin
            r[n]     = acc_q[n] >>> i_out_shift;
            sat_d[n] = !(i_relu && r[n] < 0) && (r[n] > MAXV || r[n] < MINV);
            res_d[n] = (i_relu && r[n] < 0) ? 16'h0000
                     : (r[n] > MAXV) ? 16'h7FFF
                     : (r[n] < MINV) ? 16'h8000
                     : r[n][15:0];
        end
    end

    // End-of-run delay line, capture into result/chain, sticky flags and cascade shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            chain_q <= '0;
            sat_q   <= '0;
        end else begin
            run_q  <= {run_q[1:0], i_run};
            done_q <= cap;
            sat_q  <= cap ? (sat_q | sat_d) : i_init_bias ? '0 : sat_q;
            if (cap) begin
                res_q   <= res_d;
                chain_q <= res_d;
            end else if (i_shift) begin
                chain_q <= {chain_q[LANES-2:0], i_cascade_in};
            end
        end
    end

    assign o_result      = res_q;
    assign o_cascade_out = chain_q[LANES-1];
    assign o_done        = done_q;
    assign o_sat         = sat_q;
endmodule

// File: tb/tb_audio_ice40_fc_mac_array.sv
// tb_audio_ice40_fc_mac_array: scoreboard bench for the multi-lane FC MAC array
module tb_audio_ice40_fc_mac_array;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_bias_we;
    logic [5:0]  i_bias_waddr;
    logic [63:0] i_bias_wdata;
    logic [5:0]  i_bias_addr;
    logic        i_init_bias;
    logic        i_run;
    logic [15:0] i_din;
    logic        i_din_val;
    logic [63:0] i_weight;
    logic        i_relu;
    logic [5:0]  i_out_shift;
    logic        i_shift;
    logic [15:0] i_cascade_in;
    logic [15:0] o_cascade_out;
    logic [63:0] o_result;
    logic        o_done;
    logic [3:0]  o_sat;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  sat;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] bias_mdl [64];
    int          n_chk = 0;
    int          n_fail = 0;

    audio_ice40_fc_mac_array dut (
        .clk(clk), .reset(reset),
        .i_bias_we(i_bias_we), .i_bias_waddr(i_bias_waddr), .i_bias_wdata(i_bias_wdata),
        .i_bias_addr(i_bias_addr), .i_init_bias(i_init_bias), .i_run(i_run),
        .i_din(i_din), .i_din_val(i_din_val), .i_weight(i_weight), .i_relu(i_relu),
        .i_out_shift(i_out_shift), .i_shift(i_shift), .i_cascade_in(i_cascade_in),
        .o_cascade_out(o_cascade_out), .o_result(o_result), .o_done(o_done), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic for one lane: bias aligned, n identical products, shift, relu, saturate
    function automatic logic [15:0] lane_ref(input logic [15:0] b, input logic [15:0] d,
                                             input logic [15:0] w, input int n, input logic relu,
                                             input int sh, output logic s);
        longint acc, r;
        acc = (longint'($signed(b)) * 32768) + longint'(n) * longint'($signed(d)) * longint'($signed(w));
        r   = acc >>> sh;
        s   = 1'b0;
        if (relu && r < 0) return 16'h0000;
        if (r > 32767) begin s = 1'b1; return 16'h7FFF; end
        if (r < -32768) begin s = 1'b1; return 16'h8000; end
        return r[15:0];
    endfunction

    // Output monitor: every done pulse retires one scoreboard entry
    always @(negedge clk) begin
        if (o_done) begin
            if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("result", o_result, e.res);
                check("sat", {60'd0, o_sat}, {60'd0, e.sat});
            end
        end
    end

    task automatic write_bias(input logic [5:0] a, input logic [63:0] d);
        @(negedge clk);
        i_bias_we = 1'b1; i_bias_waddr = a; i_bias_wdata = d;
        bias_mdl[a] = d;
        @(negedge clk);
        i_bias_we = 1'b0;
    endtask

    task automatic do_run(input logic [5:0] a, input logic [15:0] d, input logic [63:0] w,
                          input int n, input logic relu, input logic [5:0] sh);
        exp_t e;
        int   t;
        logic s;
        for (int l = 0; l < 4; l++) begin
            e.res[16*l +: 16] = lane_ref(bias_mdl[a][16*l +: 16], d, w[16*l +: 16], n, relu, int'(sh), s);
            e.sat[l] = s;
        end
        @(negedge clk);
        i_init_bias = 1'b1; i_bias_addr = a;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_init_bias = 1'b0; i_run = 1'b1; i_din_val = 1'b1; i_din = d; i_weight = w;
            i_relu = relu; i_out_shift = sh;
        end
        @(negedge clk);
        i_run = 1'b0; i_din_val = 1'b0; i_din = 16'h0;
        sb.push_back(e);
        for (t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (o_done) break;
        end
        check("done_latency", 64'(t), 64'd3);
        @(negedge clk);
        check("done_pulse", {63'd0, o_done}, 64'd0);
    endtask

    initial begin
        exp_t dummy;
        reset = 1'b1;
        i_bias_we = 0; i_bias_waddr = 0; i_bias_wdata = 0; i_bias_addr = 0; i_init_bias = 0;
        i_run = 0; i_din = 0; i_din_val = 0; i_weight = 0; i_relu = 0; i_out_shift = 6'd15;
        i_shift = 0; i_cascade_in = 0;
        repeat (2) @(negedge clk);
        check("rst_result", o_result, 64'd0);
        check("rst_cascade", {48'd0, o_cascade_out}, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_sat", {60'd0, o_sat}, 64'd0);
        reset = 1'b0;

        write_bias(6'd0, 64'h0);
        write_bias(6'd1, 64'h0400_0400_0400_0400);

        do_run(6'd0, 16'h4000, 64'h0400_0400_0400_0400, 4, 1'b0, 6'd15);
        check("basic_literal", o_result, 64'h0800_0800_0800_0800);
        do_run(6'd1, 16'h4000, 64'h0400_0400_0400_0400, 4, 1'b0, 6'd15);
        check("bias_literal", o_result, 64'h0C00_0C00_0C00_0C00);

        do_run(6'd0, 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 8, 1'b0, 6'd15);
        check("sat_flags", {60'd0, o_sat}, 64'hF);
        @(negedge clk); i_init_bias = 1'b1; i_bias_addr = 6'd0;
        @(negedge clk); i_init_bias = 1'b0;
        check("sat_cleared", {60'd0, o_sat}, 64'd0);
        repeat (2) @(negedge clk);

        do_run(6'd0, 16'h4000, 64'hFC00_FC00_FC00_FC00, 4, 1'b0, 6'd15);
        check("neg_literal", o_result, 64'hF800_F800_F800_F800);
        do_run(6'd0, 16'h4000, 64'hFC00_FC00_FC00_FC00, 4, 1'b1, 6'd15);
        check("relu_literal", o_result, 64'h0);

        do_run(6'd0, 16'h4000, 64'h1000_0C00_0800_0400, 4, 1'b0, 6'd15);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] v;
            v = 64'h2000_1800_1000_0800;
            check("cascade_drain", {48'd0, o_cascade_out}, {48'd0, v[16*(3-i) +: 16]});
            i_shift = 1'b1; i_cascade_in = 16'h1234;
            @(negedge clk);
        end
        i_cascade_in = 16'h0;
        for (int i = 0; i < 4; i++) begin
            check("cascade_fill", {48'd0, o_cascade_out}, 64'h1234);
            @(negedge clk);
        end
        i_shift = 1'b0;

        @(negedge clk); i_init_bias = 1'b1; i_bias_addr = 6'd1;
        @(negedge clk); i_init_bias = 1'b0; i_run = 1'b1; i_din_val = 1'b1;
        i_din = 16'h4000; i_weight = 64'h7FFF_7FFF_7FFF_7FFF;
        repeat (3) @(negedge clk);
        reset = 1'b1; i_run = 1'b0; i_din_val = 1'b0;
        @(negedge clk);
        check("midrst_result", o_result, 64'd0);
        check("midrst_cascade", {48'd0, o_cascade_out}, 64'd0);
        check("midrst_done", {63'd0, o_done}, 64'd0);
        check("midrst_sat", {60'd0, o_sat}, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_run(6'd1, 16'h4000, 64'h0400_0400_0400_0400, 4, 1'b0, 6'd15);
        check("post_rst_literal", o_result, 64'h0C00_0C00_0C00_0C00);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_ice40_fc_mac_array.md
# audio_ice40_fc_mac_array

Parametrised multi-lane fully-connected execution unit for the keyword-spotting FC layer on iCE40. It replaces the single-lane FC execution unit. LANES output neurons share one broadcast input stream; each lane has its own weight, a bias memory, runtime output shift, optional ReLU and saturation. Results are captured in parallel at end of run, then drained through a 16-bit cascade shift chain into neighbouring arrays or the layer writer.

## Interface
- DW, 16: input sample width, signed (Q1.15).
- WW, 16: weight width per lane, signed (Q5.10).
- AW, 40: accumulator width, signed; requires AW ≥ DW+WW+8.
- LANES, 4: number of parallel MAC lanes / neurons.
- BIAS_DEPTH, 64: bias memory depth; each word holds LANES×16-bit biases.
- BIAS_SHIFT, 15: left shift that aligns a Q5.10 bias to the Q6.25 accumulator.
- clk  in  1: single clock; all state changes on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- i_bias_we  in  1: bias memory write strobe.
- i_bias_waddr  in  log2(BIAS_DEPTH): bias write address.
- i_bias_wdata  in  LANES×16: bias write data; lane n is bits [16n+15:16n].
- i_bias_addr  in  log2(BIAS_DEPTH): bias read address used by i_init_bias.
- i_init_bias  in  1: load accumulators from bias word i_bias_addr.
- i_run  in  1: run window; products are accumulated only while high.
- i_din  in  DW: broadcast input sample.
- i_din_val  in  1: i_din valid.
- i_weight  in  LANES×WW: per-lane weights, aligned with i_din.
- i_relu  in  1: ReLU enable, sampled at capture.
- i_out_shift  in  6: arithmetic right shift applied at capture (15 = Q5.10 out).
- i_shift  in  1: advance the cascade chain by one lane.
- i_cascade_in  in  16: chain input into lane 0.
- o_cascade_out  out  16: chain output, taken from lane LANES-1.
- o_result  out  LANES×16: parallel captured results.
- o_done  out  1: one-cycle pulse when o_result and the chain are loaded.
- o_sat  out  LANES: per-lane saturation flags, sticky from capture until the next i_init_bias.

## Operation
- Pipeline, per lane:
  - S0 registers din/weight/valid when i_run=1. din is forced to 0 when i_din_val=0. When i_run=0, S0 is zeroed.
  - S1 is a registered DW×WW signed multiply.
  - S2: accu += sign-extended product when the valid delayed by two stages is 1.
- Bias load is two stages:
  - Edge 1 reads the bias word at i_bias_addr.
  - Edge 2 sets accu = sext(bias) << BIAS_SHIFT for every lane.
  - On that edge the bias load wins over any accumulate, and that product is discarded.
- Bias memory has a synchronous write. A read and a write to the same address in the same cycle return the old data.
- End-of-run detection is a 3-deep delay of i_run; capture fires when the delayed pattern shows a falling edge that has been flushed through S2.
- Capture, per lane:
  - r = accu >>> i_out_shift (arithmetic).
  - If i_relu=1 and r<0, the result is 0.
  - Else if r > 32767 the result is 0x7FFF and o_sat[n] is set; if r < −32768 the result is 0x8000 and o_sat[n] is set.
  - Else the result is r[15:0].
  - Results load into o_result and the chain registers.
- Chain: on i_shift, chain[0] ← i_cascade_in and chain[n] ← chain[n−1]. o_cascade_out = chain[LANES−1], so lane LANES−1 leaves first.
- Capture and i_shift in the same cycle: capture wins and the shift is dropped.
- Reset mid-operation clears the pipeline, accumulators, delay line, chain, flags and bias-read register. Bias memory contents are undefined after reset.

## Timing
- Reset values: o_cascade_out=0, o_result=0, o_done=0, o_sat=0.
- Sample accepted at edge k (i_run=1, i_din_val=1) is in accu after edge k+2.
- i_run last sampled high at edge k: capture, o_result, chain and o_sat update at edge k+3. o_done is high during the cycle after edge k+3.
- i_init_bias sampled at edge j: accu holds the bias after edge j+1. A sample accepted at edge j+1 or later is accumulated on top of it.
- Protocol: i_run stays low ≥3 cycles between runs, and i_init_bias is issued before each run. Violating either is unsupported.
- Chain: each i_shift edge advances by exactly one lane. LANES shifts drain a standalone array.

## Test plan
- Bias 0, 4 samples of din=0x4000 with all weights 0x0400, i_out_shift=15 -> o_result lanes all 0x0800. o_done pulses at k+3; o_sat=0.
- Bias word 0x0400 in all lanes, same stimulus -> 0x0C00 per lane.
- 8 samples of din=0x7FFF with weight 0x7FFF -> 0x7FFF and o_sat set. The next i_init_bias clears o_sat.
- Weight 0xFC00, din=0x4000, 4 samples: i_relu=0 gives 0xF800; i_relu=1 gives 0x0000.
- Lanes with distinct results A,B,C,D (lanes 0..3), i_cascade_in=0x1234, 4 shifts -> o_cascade_out shows D, C, B, A. The chain then holds 0x1234 in every lane.
- Assert reset during the accumulate phase -> all outputs are 0 on the next cycle. A new run after i_init_bias gives correct results with no carry-over.
